// File: rtl/ldmx_axil_arb_pkg.sv
// ldmx_axil_arb_pkg: shared FSM encoding, response codes and bus widths for axil_req_arbiter
package ldmx_axil_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'h0;
    localparam logic [1:0] RESP_SLVERR = 2'h3;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/axil_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner, searching upward from last+1 with wrap
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last,
    output logic            any,
    output logic [GW-1:0]   gnt
);

    // Lowest requester above last wins; otherwise wrap to the lowest requester at or below last.
    always_comb begin
        any = |req;
        gnt = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i] && i <= int'(last)) gnt = GW'(i);
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i] && i > int'(last)) gnt = GW'(i);
    end

endmodule

// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter: round-robin funnel of NREQ requesters onto one read/write register channel.
// Optional WAIT watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_req_arbiter
    import ldmx_axil_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   axilClk,
    input  logic                   axilRst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_rnw,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [1:0]             rsp_resp,
    output logic [ADDR_W-1:0]      raddr,
    output logic                   rstart,
    output logic                   rready,
    input  logic                   rvalid,
    input  logic [DATA_W-1:0]      rdata,
    input  logic [1:0]             rresp,
    output logic [ADDR_W-1:0]      waddr,
    output logic [DATA_W-1:0]      wdata,
    output logic                   wstart,
    output logic                   bready,
    input  logic                   bvalid,
    input  logic [1:0]             bresp
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              state_q, state_d;
    logic [GW-1:0]       last_q, last_d, gnt_q, gnt_d, win;
    logic                rnw_q, rnw_d, any;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d, data_q, data_d;
    logic [1:0]          resp_q, resp_d;
`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]       cnt_q, cnt_d;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req  (req_valid),
        .last (last_q),
        .any  (any),
        .gnt  (win)
    );

    // Next-state logic: grant in IDLE, issue one start pulse, wait for the matching channel, respond.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        data_d    = data_q;
        resp_d    = resp_q;
        req_ready = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: if (any && !axilRst) begin
                req_ready[win] = 1'b1;
                gnt_d   = win;
                last_d  = win;
                rnw_d   = req_rnw[win];
                addr_d  = req_addr[win*ADDR_W +: ADDR_W];
                wdat_d  = req_wdata[win*DATA_W +: DATA_W];
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef AXIL_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: if (rnw_q && rvalid) begin
                data_d  = rdata;
                resp_d  = rresp;
                state_d = RESP;
            end else if (!rnw_q && bvalid) begin
                data_d  = '0;
                resp_d  = bresp;
                state_d = RESP;
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                data_d  = TIMEOUT_DATA;
                resp_d  = RESP_SLVERR;
                state_d = RESP;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge axilClk or posedge axilRst) begin
        if (axilRst) begin
            state_q <= IDLE;
            last_q  <= GW'(NREQ - 1);
            gnt_q   <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            data_q  <= '0;
            resp_q  <= RESP_OKAY;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign rstart    = state_q == ISSUE && rnw_q;
    assign wstart    = state_q == ISSUE && !rnw_q;
    assign rready    = state_q == WAIT && rnw_q;
    assign bready    = state_q == WAIT && !rnw_q;
    assign rsp_valid = (state_q == RESP) ? NREQ'(1) << gnt_q : '0;
    assign rsp_data  = data_q;
    assign rsp_resp  = resp_q;
    assign raddr     = rnw_q ? addr_q : '0;
    assign waddr     = rnw_q ? '0 : addr_q;
    assign wdata     = rnw_q ? '0 : wdat_q;

endmodule

// File: doc/axil_req_arbiter.md
AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of register-bus requesters (1..8).
REQ-002 Parameter: TIMEOUT_CYCLES, default 1024, WAIT-state watchdog limit in axilClk cycles.
REQ-003 Port: axilClk  in  1  the block's single clock.
REQ-004 Port: axilRst  in  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  in  NREQ  per-requester request, held until accepted.
REQ-006 Port: req_rnw  in  NREQ  1=read, 0=write.
REQ-007 Port: req_addr  in  18*NREQ  word address, requester i at bits [18i+17:18i].
REQ-008 Port: req_wdata  in  32*NREQ  write data, requester i at bits [32i+31:32i].
REQ-009 Port: req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
REQ-010 Port: rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 Port: rsp_data  out  32  read data, valid with rsp_valid.
REQ-012 Port: rsp_resp  out  2  0=OKAY, 3=SLVERR.
REQ-013 Ports: raddr out 18, rstart out 1, rready out 1, rvalid in 1, rdata in 32, rresp in 2  downstream read channel.
REQ-014 Ports: waddr out 18, wdata out 32, wstart out 1, bready out 1, bvalid in 1, bresp in 2  downstream write channel.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any req_valid, grant the round-robin winner, pulse its req_ready, latch rnw/addr/wdata, go to ISSUE.
REQ-017 Round-robin: search starts at (last_grant+1) mod NREQ; after reset last_grant=NREQ-1, so requester 0 has first priority.
REQ-018 ISSUE: one-cycle pulse on rstart (read) or wstart (write) with latched raddr or waddr/wdata; go to WAIT.
REQ-019 raddr/waddr/wdata hold latched values from ISSUE until leaving WAIT.
REQ-020 WAIT: rready=1 (read) or bready=1 (write); on rvalid&rready capture rdata/rresp, on bvalid&bready capture bresp with rsp_data=0; go to RESP.
REQ-021 RESP: pulse rsp_valid[grant] for one cycle with captured data/resp; go to IDLE.
REQ-022 Latency: request accepted in IDLE -> start pulse next cycle; downstream response at cycle N -> rsp_valid at N+1; minimum back-to-back spacing 4 cycles.
REQ-023 A requester that drops req_valid before req_ready is not granted; at most one transaction is outstanding.
REQ-024 Response beats arriving outside WAIT, or on the channel not in use, are dropped with rready/bready=0 and no rsp_valid.
REQ-025 req_ready, rsp_valid, rstart, wstart are never asserted for more than one consecutive cycle.

Reset
REQ-026 axilRst asserted: FSM=IDLE, last_grant=NREQ-1, and all outputs 0, effective immediately without a clock edge.
REQ-027 Reset during WAIT abandons the transaction; no rsp_valid is issued for it after reset is released.

Configuration
REQ-028 Macro AXIL_ARB_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without a response, go to RESP with rsp_resp=3 and rsp_data=32'hDEADBEEF.
REQ-029 Macro AXIL_ARB_TIMEOUT_EN undefined: no counter is built and WAIT persists until a response arrives.

Structure
REQ-030 Package ldmx_axil_arb_pkg holds the FSM state encoding, RESP_OKAY=2'h0, RESP_SLVERR=2'h3, ADDR_W=18, DATA_W=32.
REQ-031 Sub-module rr_arbiter (combinational winner from request vector and last_grant) is instantiated once.

Verification
REQ-032 Single read: req 0 reads 0x00100; rvalid with rdata=0x12345678, rresp=0 two cycles after rstart -> rsp_valid[0], rsp_data=0x12345678, rsp_resp=0.
REQ-033 Contention: req 0 and req 1 both valid continuously -> grants alternate 0,1,0,1 and each request gets exactly one req_ready.
REQ-034 Write: req 1 writes 0x11000 with data 0xA5A5A5A5; bresp=3 -> wstart with waddr=0x11000 and wdata=0xA5A5A5A5, then rsp_valid[1] with rsp_resp=3 and rsp_data=0.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=16): no rvalid -> rsp_resp=3 and rsp_data=0xDEADBEEF at cycle 16 of WAIT; a late rvalid is dropped.
REQ-036 Reset mid-WAIT: assert axilRst asynchronously -> all outputs 0 at once; after release, req 0 wins the first grant and no stale rsp_valid appears.
